rr_packet_mux: RTL and testbench

//  - Sits directly downstream of round_robin_arbiter: drives its request vector and consumes its one-hot grant.
//  - Locks the grant for the length of a multi-beat packet.
//  - Muxes the selected source's data onto a single valid/ready output through one register stage.
//  - Result: whole packets from NUM_REQ sources, interleaved fairly at packet boundaries, never mid-packet.

---
 rtl/rr_packet_mux.sv | 112 +++++++++++
 tb/tb_rr_packet_mux.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_mux.sv
// Packet-locking mux behind a round-robin arbiter.
// Whole packets are forwarded through one output register stage.
module rr_packet_mux #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_last,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic [NUM_REQ-1:0]        arb_req,
  input  logic [NUM_REQ-1:0]        arb_grant,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [NUM_REQ-1:0]        out_src,
  input  logic                      out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic [NUM_REQ-1:0] sel, sel_n;
  logic [NUM_REQ-1:0] gsel, cand, take;
  logic [DATA_W-1:0]  mux_data;
  logic               mux_last;
  logic               load_en;
  logic               grant_ok;

  assign load_en  = !out_valid | out_ready;
  assign gsel     = arb_grant & in_valid;
  assign grant_ok = (arb_grant != '0) &&
                    ((arb_grant & (arb_grant - NUM_REQ'(1))) == '0);
  assign cand     = (state == LOCKED) ? sel : gsel;

  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand[i]) begin
        mux_data = mux_data | in_data[i*DATA_W +: DATA_W];
        mux_last = mux_last | in_last[i];
      end
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    arb_req  = in_valid;
    in_ready = '0;
    take     = '0;
    unique case (state)
      IDLE: begin
        if (grant_ok && (gsel != '0) && load_en) begin
          in_ready = gsel;
          take     = gsel;
          if (!mux_last) begin
            sel_n   = gsel;
            state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        // Holding the request on sel keeps the arbiter parked there.
        arb_req = sel;
        if (load_en) begin
          in_ready = sel;
          take     = sel & in_valid;
          if ((take != '0) && mux_last) begin
            sel_n   = '0;
            state_n = IDLE;
          end
        end
      end
    endcase
    if (!rstn) in_ready = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (take != '0) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= mux_last;
      out_src   <= take;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_packet_mux.sv
// Directed bench for rr_packet_mux with a round-robin arbiter model
// and a scoreboard of expected output beats.
module tb_rr_packet_mux;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [N-1:0] s;
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_last = '0;
  logic [N-1:0] in_ready;
  logic [N-1:0] arb_req;
  logic [N-1:0] arb_grant;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [N-1:0] out_src;
  logic         out_ready = 1'b1;

  beat_t src_q[N][$];
  exp_t  sb[$];
  exp_t  mon_e;
  int    cyc_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  logic [N-1:0] hold = '0;
  logic [N-1:0] hs_s = '0;
  logic [N-1:0] base;
  logic         bad_en = 1'b0;
  logic [N-1:0] bad_val = '0;
  logic         found;
  int           bi;

  rr_packet_mux #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Arbiter model: first requester at or after base.
  always_comb begin
    arb_grant = '0;
    found     = 1'b0;
    bi        = 0;
    for (int i = 0; i < N; i++)
      if (base[i]) bi = i;
    for (int k = 0; k < N; k++) begin
      if (!found && arb_req[(bi + k) % N]) begin
        arb_grant[(bi + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
    if (bad_en) arb_grant = bad_val;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) base <= 4'b0001;
    else if (hs_s != '0) base <= {hs_s[N-2:0], hs_s[N-1]};
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) hs_s = in_valid & in_ready;

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 64'(out_data), 64'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("out_src", 64'(out_src), 64'(mon_e.s));
        chk("out_data", 64'(out_data), 64'(mon_e.d));
        chk("out_last", 64'(out_last), 64'(mon_e.l));
        cyc_q.push_back(cyc);
      end
    end
  end

  // Source driver: retire accepted beats, then present queue heads.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++)
      if (hs_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    #1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]         = !hold[i];
        in_data[i*W +: W]   = src_q[i][0].d;
        in_last[i]          = src_q[i][0].l;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[i*W +: W]   = '0;
        in_last[i]          = 1'b0;
      end
    end
  end

  function automatic logic [W-1:0] mk(int s, int k, int pid);
    return W'((pid << 16) | (s << 8) | k);
  endfunction

  task automatic send(input int s, input int n, input int pid);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = mk(s, k, pid);
      b.l = (k == n - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int s, input int n, input int pid);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.s = N'(1 << s);
      e.d = mk(s, k, pid);
      e.l = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      step();
      done = (sb.size() == 0) && !out_valid;
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0) done = 1'b0;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rstn = 1'b1;
    step();

    // Single-beat packets from all sources
    cyc_q.delete();
    send(0, 1, 1); send(1, 1, 2); send(2, 1, 3);
    send(3, 1, 4); send(0, 1, 5);
    expect_pkt(0, 1, 1); expect_pkt(1, 1, 2); expect_pkt(2, 1, 3);
    expect_pkt(3, 1, 4); expect_pkt(0, 1, 5);
    drain("drain_single");
    chk("single_count", 64'(cyc_q.size()), 64'd5);
    for (int i = 1; i < 5 && i < cyc_q.size(); i++)
      chk("single_rate", 64'(cyc_q[i] - cyc_q[i-1]), 64'd1);

    // Grant lock over a 4-beat packet
    send(1, 4, 10); send(0, 1, 11); send(2, 1, 12); send(3, 1, 13);
    expect_pkt(1, 4, 10); expect_pkt(2, 1, 12);
    expect_pkt(3, 1, 13); expect_pkt(0, 1, 11);
    drain("drain_lock");

    // Backpressure mid-packet
    send(1, 5, 20);
    expect_pkt(1, 5, 20);
    step(); step();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (sb.size() > 0) begin
        chk("bp_data", 64'(out_data), 64'(sb[0].d));
        chk("bp_src", 64'(out_src), 64'(sb[0].s));
        chk("bp_last", 64'(out_last), 64'(sb[0].l));
      end
      step();
    end
    out_ready = 1'b1;
    drain("drain_bp");

    // Bubble in a locked packet
    send(3, 4, 30); send(0, 1, 31);
    expect_pkt(3, 4, 30); expect_pkt(0, 1, 31);
    step(); step();
    hold[3] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bubble_src0_ready", 64'(in_ready[0]), 64'd0);
    end
    hold[3] = 1'b0;
    drain("drain_bubble");

    // Non-one-hot grant in IDLE
    bad_en = 1'b1;
    bad_val = 4'b0011;
    send(0, 1, 40);
    expect_pkt(0, 1, 40);
    step();
    chk("bad_arb_req", 64'(arb_req), 64'b0001);
    chk("bad_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("bad_out_valid", 64'(out_valid), 64'd0);
    bad_en = 1'b0;
    drain("drain_bad");

    // Asynchronous reset mid-packet
    out_ready = 1'b0;
    send(2, 4, 50);
    repeat (3) step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_src", 64'(out_src), 64'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    step();
    out_ready = 1'b1;
    send(1, 1, 60); send(3, 1, 61);
    step();
    rstn = 1'b1;
    #1;
    chk("post_rst_req", 64'(arb_req), 64'b1010);
    chk("post_rst_ready", 64'(in_ready), 64'b0010);
    expect_pkt(1, 1, 60); expect_pkt(3, 1, 61);
    drain("drain_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
